// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: host command engine turning a UART byte stream into GPIO, cfg-register and 16-bit memory accesses.
// Latency: pin/reg writes and 1-byte replies land one cycle after the final byte; mem_req rises one cycle after the last needed byte.
// Backpressure: tx byte held until tx_ready, mem_req held until mem_ack; rx is never stalled, a 1-byte hold absorbs bytes while busy.
// Ports:
//   sys_clk, sys_rst_n            clock, async active-low reset
//   rx_valid, rx_data             incoming byte stream (one-cycle pulses)
//   tx_valid, tx_data, tx_ready   reply bytes, ready/valid handshake
//   mem_req/we/addr/wdata         memory master request, held until mem_ack
//   mem_rdata, mem_ack            memory completion (rdata valid with ack)
//   in_pins, out_pins             sampled / driven GPIO bytes
//   cfg_regs                      host-written config register bank
//   out_clk, out_rst              host-driven clock and reset pins
//   busy, err_count               FSM not idle / saturating error count
module uart_cmd_bridge #(
  parameter int N_IN    = 8,
  parameter int N_OUT   = 8,
  parameter int N_REGS  = 8,
  parameter int ADDR_B  = 3,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [8*ADDR_B-1:0]   mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack,
  input  logic [8*N_IN-1:0]     in_pins,
  output logic [8*N_OUT-1:0]    out_pins,
  output logic [8*N_REGS-1:0]   cfg_regs,
  output logic                  out_clk,
  output logic                  out_rst,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int ADDR_W = 8 * ADDR_B;
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [4:0]      N_IN_L   = 5'(N_IN);
  localparam logic [4:0]      N_OUT_L  = 5'(N_OUT);
  localparam logic [4:0]      N_REGS_L = 5'(N_REGS);
  localparam logic [3:0]      IA       = 4'(ADDR_B);   // arg index of the first byte after the address
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

  localparam logic [7:0] OP_MWR = 8'hA0;
  localparam logic [7:0] OP_MRD = 8'hA1;
  localparam logic [7:0] OP_BWR = 8'hA2;
  localparam logic [7:0] OP_BRD = 8'hA3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARG  = 2'd1,
    S_MEM  = 2'd2,
    S_TX   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [3:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [7:0]          rhi_q, rhi_d;
  logic                tx_hi_q, tx_hi_d;
  logic                tx_vld_q, tx_vld_d;
  logic [7:0]          tx_dat_q, tx_dat_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                hold_vld_q, hold_vld_d;
  logic [7:0]          hold_q, hold_d;
  logic                abort_q, abort_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]          err_q, err_d;
  logic [8*N_OUT-1:0]  out_pins_q, out_pins_d;
  logic [8*N_REGS-1:0] cfg_q, cfg_d;
  logic                out_clk_q, out_clk_d;
  logic                out_rst_q, out_rst_d;

  logic       cmd_vld;
  logic [7:0] cmd_dat;
  logic [3:0] nib;
  logic [7:0] in_sel;
  logic [7:0] cfg_sel;
  logic       err_evt;
  logic       timeout;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    rhi_d      = rhi_q;
    tx_hi_d    = tx_hi_q;
    tx_vld_d   = tx_vld_q;
    tx_dat_d   = tx_dat_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    abort_d    = abort_q;
    to_cnt_d   = '0;
    out_pins_d = out_pins_q;
    cfg_d      = cfg_q;
    out_clk_d  = out_clk_q;
    out_rst_d  = out_rst_q;
    err_evt    = 1'b0;
    timeout    = 1'b0;
    cmd_vld    = 1'b0;
    // A held byte is older than anything arriving now, so it is parsed first.
    cmd_dat    = hold_vld_q ? hold_q : rx_data;
    nib        = cmd_dat[3:0];

    in_sel = 8'h00;
    for (int p = 0; p < N_IN; p++) begin
      if (nib == 4'(p)) in_sel = in_pins[8*p +: 8];
    end
    cfg_sel = 8'h00;
    for (int r = 0; r < N_REGS; r++) begin
      if (nib == 4'(r)) cfg_sel = cfg_q[8*r +: 8];
    end

    // Byte intake: parsed directly while IDLE/ARG, parked in the hold while MEM/TX.
    if (state_q == S_IDLE || state_q == S_ARG) begin
      cmd_vld = hold_vld_q | rx_valid;
      if (hold_vld_q) begin
        // hold drains this cycle; a byte arriving now takes its place
        hold_vld_d = rx_valid;
        hold_d     = rx_data;
      end
    end else if (rx_valid) begin
      if (hold_vld_q) begin
        err_evt = 1'b1;
        abort_d = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = rx_data;
      end
    end

    // Inter-byte gap counter, only meaningful while collecting arguments.
    if (state_q == S_ARG && !cmd_vld) begin
      timeout  = (to_cnt_q == TO_LAST);
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_vld) begin
          op_d  = cmd_dat;
          idx_d = '0;
          case (cmd_dat[7:4])
            4'h1: begin
              case (nib)
                4'h0:    out_clk_d = 1'b1;
                4'h1:    out_clk_d = 1'b0;
                4'h2:    out_rst_d = 1'b1;
                4'h3:    out_rst_d = 1'b0;
                default: err_evt   = 1'b1;
              endcase
            end
            4'h2: begin
              if ({1'b0, nib} < N_IN_L) begin
                tx_dat_d = in_sel;
                tx_vld_d = 1'b1;
                state_d  = S_TX;
              end else begin
                err_evt = 1'b1;
              end
            end
            4'h3: begin
              if ({1'b0, nib} < N_OUT_L) state_d = S_ARG;
              else                       err_evt = 1'b1;
            end
            4'h4: begin
              if ({1'b0, nib} < N_REGS_L) state_d = S_ARG;
              else                        err_evt = 1'b1;
            end
            4'h5: begin
              if ({1'b0, nib} < N_REGS_L) begin
                tx_dat_d = cfg_sel;
                tx_vld_d = 1'b1;
                state_d  = S_TX;
              end else begin
                err_evt = 1'b1;
              end
            end
            4'hA: begin
              if (nib < 4'h4) state_d = S_ARG;
              else            err_evt = 1'b1;
            end
            default: err_evt = 1'b1;
          endcase
        end
      end

      S_ARG: begin
        if (timeout) begin
          err_evt = 1'b1;
          state_d = S_IDLE;
        end else if (cmd_vld) begin
          idx_d = idx_q + 4'd1;
          if (op_q[7:4] == 4'h3) begin
            for (int p = 0; p < N_OUT; p++) begin
              if (op_q[3:0] == 4'(p)) out_pins_d[8*p +: 8] = cmd_dat;
            end
            state_d = S_IDLE;
          end else if (op_q[7:4] == 4'h4) begin
            for (int r = 0; r < N_REGS; r++) begin
              if (op_q[3:0] == 4'(r)) cfg_d[8*r +: 8] = cmd_dat;
            end
            state_d = S_IDLE;
          end else if (idx_q < IA) begin
            // address bytes arrive LSB first
            for (int b = 0; b < ADDR_B; b++) begin
              if (idx_q == 4'(b)) addr_d[8*b +: 8] = cmd_dat;
            end
            if (op_q == OP_MRD && idx_q == IA - 4'd1) begin
              mem_req_d = 1'b1;
              mem_we_d  = 1'b0;
              state_d   = S_MEM;
            end
          end else if (idx_q == IA) begin
            if (op_q == OP_MWR) begin
              wdata_d[7:0] = cmd_dat;
            end else begin
              len_d = cmd_dat;
              if (op_q == OP_BRD) begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b0;
                state_d   = S_MEM;
              end
            end
          end else if ((op_q == OP_MWR && idx_q == IA + 4'd1) ||
                       (op_q == OP_BWR && idx_q == IA + 4'd2)) begin
            wdata_d[15:8] = cmd_dat;
            mem_req_d     = 1'b1;
            mem_we_d      = 1'b1;
            state_d       = S_MEM;
          end else begin
            // burst-write low data byte
            wdata_d[7:0] = cmd_dat;
          end
        end
      end

      S_MEM: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (abort_q) begin
            // overrun seen during this access: drop the rest of the command and the stale hold
            abort_d    = 1'b0;
            hold_vld_d = 1'b0;
            state_d    = S_IDLE;
          end else if (op_q == OP_BWR && len_q != 8'd0) begin
            len_d   = len_q - 8'd1;
            addr_d  = addr_q + ADDR_W'(1);
            idx_d   = IA + 4'd1;
            state_d = S_ARG;
          end else if (mem_we_q) begin
            state_d = S_IDLE;
          end else begin
            tx_dat_d = mem_rdata[7:0];
            rhi_d    = mem_rdata[15:8];
            tx_hi_d  = 1'b0;
            tx_vld_d = 1'b1;
            state_d  = S_TX;
          end
        end
      end

      S_TX: begin
        if (tx_ready) begin
          tx_vld_d = 1'b0;
          state_d  = S_IDLE;
          if (abort_q) begin
            abort_d    = 1'b0;
            hold_vld_d = 1'b0;
          end else if (op_q[7:4] == 4'hA) begin
            if (!tx_hi_q) begin
              tx_dat_d = rhi_q;
              tx_hi_d  = 1'b1;
              tx_vld_d = 1'b1;
              state_d  = S_TX;
            end else if (op_q == OP_BRD && len_q != 8'd0) begin
              // next burst word only once both bytes of this one have left
              len_d     = len_q - 8'd1;
              addr_d    = addr_q + ADDR_W'(1);
              mem_req_d = 1'b1;
              mem_we_d  = 1'b0;
              state_d   = S_MEM;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Coincident error sources collapse into one increment.
    err_d = err_q;
    if (err_evt && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      rhi_q      <= '0;
      tx_hi_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_dat_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      abort_q    <= 1'b0;
      to_cnt_q   <= '0;
      err_q      <= '0;
      out_pins_q <= '0;
      cfg_q      <= '0;
      out_clk_q  <= 1'b0;
      out_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      rhi_q      <= rhi_d;
      tx_hi_q    <= tx_hi_d;
      tx_vld_q   <= tx_vld_d;
      tx_dat_q   <= tx_dat_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
      abort_q    <= abort_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      out_pins_q <= out_pins_d;
      cfg_q      <= cfg_d;
      out_clk_q  <= out_clk_d;
      out_rst_q  <= out_rst_d;
    end
  end

  assign tx_valid  = tx_vld_q;
  assign tx_data   = tx_dat_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign out_pins  = out_pins_q;
  assign cfg_regs  = cfg_q;
  assign out_clk   = out_clk_q;
  assign out_rst   = out_rst_q;
  assign busy      = (state_q != S_IDLE);
  assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb_uart_cmd_bridge: directed bench for uart_cmd_bridge with tx and memory scoreboards.
// Latency: checks single-cycle effects right after the capturing edge.
// Backpressure: tx_ready held high; mem_ack driven by the sequence to stall accesses.
module tb_uart_cmd_bridge;
  localparam int TO = 40;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready  = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack   = 1'b0;
  logic [63:0] in_pins   = 64'h8877_6655_4433_2211;
  logic [63:0] out_pins;
  logic [63:0] cfg_regs;
  logic        out_clk;
  logic        out_rst;
  logic        busy;
  logic [7:0]  err_count;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_bridge #(.TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .in_pins(in_pins), .out_pins(out_pins), .cfg_regs(cfg_regs),
    .out_clk(out_clk), .out_rst(out_rst), .busy(busy), .err_count(err_count)
  );

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } mreq_t;

  int          total = 0;
  int          bad   = 0;
  mreq_t       exp_mem[$];
  logic [7:0]  exp_tx[$];
  logic [63:0] exp_out = '0;
  logic [63:0] exp_cfg = '0;
  logic [7:0]  exp_err = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tx scoreboard: every accepted byte must match the oldest expected one
  always @(negedge sys_clk) begin
    if (sys_rst_n && tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        total++;
        assert (exp_tx.size() != 0) else begin
          bad++;
          $error("FAIL tx_unexpected observed=%0h expected=none", tx_data);
        end
      end else begin
        chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx.pop_front()});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic mem_expect(input string tag);
    mreq_t e;
    int    n;
    n = 0;
    while (!mem_req && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
    e = exp_mem.pop_front();
    chk({tag, "_we"}, {63'd0, mem_we}, {63'd0, e.we});
    chk({tag, "_addr"}, {40'd0, mem_addr}, {40'd0, e.addr});
    if (e.we) chk({tag, "_wdata"}, {48'd0, mem_wdata}, {48'd0, e.wdata});
  endtask

  task automatic mem_ack_pulse(input logic [15:0] r);
    mem_rdata = r;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    chk("req_drop", {63'd0, mem_req}, 64'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    tick(3);
    chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    chk("rst_mem_req",  {63'd0, mem_req}, 64'd0);
    chk("rst_out_pins", out_pins, 64'd0);
    chk("rst_cfg",      cfg_regs, 64'd0);
    chk("rst_busy",     {63'd0, busy}, 64'd0);
    chk("rst_err",      {56'd0, err_count}, 64'd0);
    chk("rst_pins",     {62'd0, out_clk, out_rst}, 64'd0);
    sys_rst_n = 1'b1;
    tick(2);

    // host clock / reset pins
    send(8'h10); send(8'h12);
    chk("pins_set", {62'd0, out_clk, out_rst}, 64'd3);
    send(8'h11); send(8'h13);
    chk("pins_clr", {62'd0, out_clk, out_rst}, 64'd0);

    // port and cfg writes, including the top index
    send(8'h32); send(8'hA5); exp_out[23:16] = 8'hA5;
    chk("out2", out_pins, exp_out);
    send(8'h30); send(8'h5A); exp_out[7:0] = 8'h5A;
    send(8'h37); send(8'hC0); exp_out[63:56] = 8'hC0;
    chk("out0_7", out_pins, exp_out);
    send(8'h43); send(8'hC3); exp_cfg[31:24] = 8'hC3;
    send(8'h47); send(8'h7E); exp_cfg[63:56] = 8'h7E;
    chk("cfg", cfg_regs, exp_cfg);
    chk("wr_busy", {63'd0, busy}, 64'd0);

    // one-byte replies
    exp_tx.push_back(8'hC3);
    send(8'h53);
    chk("cfg_rd_vld", {63'd0, tx_valid}, 64'd1);
    wait_idle("cfg_rd_idle");
    exp_tx.push_back(8'h66);
    send(8'h25);
    chk("pin_rd_vld", {63'd0, tx_valid}, 64'd1);
    wait_idle("pin_rd_idle");
    exp_tx.push_back(8'h88);
    send(8'h27);
    wait_idle("pin7_idle");

    // single write with a stalled ack
    exp_mem.push_back('{we: 1'b1, addr: 24'h000010, wdata: 16'h1234});
    send(8'hA0); send(8'h10); send(8'h00); send(8'h00); send(8'h34);
    chk("a0_early", {63'd0, mem_req}, 64'd0);
    send(8'h12);
    chk("a0_req_next", {63'd0, mem_req}, 64'd1);
    mem_expect("a0");
    tick(5);
    chk("a0_hold", {63'd0, mem_req}, 64'd1);
    mem_ack_pulse(16'h0000);
    wait_idle("a0_idle");

    // stray ack while idle
    mem_ack = 1'b1; tick(); mem_ack = 1'b0; tick();
    chk("stray_ack", {62'd0, busy, mem_req}, 64'd0);

    // single read
    exp_mem.push_back('{we: 1'b0, addr: 24'h000020, wdata: 16'h0000});
    send(8'hA1); send(8'h20); send(8'h00); send(8'h00);
    mem_expect("a1");
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
    mem_ack_pulse(16'hBEEF);
    wait_idle("a1_idle");

    // burst read across the top of the address space
    exp_mem.push_back('{we: 1'b0, addr: 24'hFFFFFE, wdata: 16'h0000});
    exp_mem.push_back('{we: 1'b0, addr: 24'hFFFFFF, wdata: 16'h0000});
    send(8'hA3); send(8'hFE); send(8'hFF); send(8'hFF); send(8'h01);
    mem_expect("a3w0");
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h11);
    mem_ack_pulse(16'h1111);
    chk("a3_gap", {63'd0, mem_req}, 64'd0);
    mem_expect("a3w1");
    exp_tx.push_back(8'h22); exp_tx.push_back(8'h22);
    mem_ack_pulse(16'h2222);
    wait_idle("a3_idle");
    chk("a3_drained", 64'(exp_tx.size()), 64'd0);

    // burst write wrapping to address 0
    exp_mem.push_back('{we: 1'b1, addr: 24'hFFFFFF, wdata: 16'hABCD});
    exp_mem.push_back('{we: 1'b1, addr: 24'h000000, wdata: 16'h5678});
    send(8'hA2); send(8'hFF); send(8'hFF); send(8'hFF); send(8'h01);
    send(8'hCD); send(8'hAB);
    mem_expect("a2w0");
    mem_ack_pulse(16'h0000);
    chk("a2_mid_busy", {63'd0, busy}, 64'd1);
    send(8'h78); send(8'h56);
    mem_expect("a2w1");
    mem_ack_pulse(16'h0000);
    wait_idle("a2_idle");

    // byte-gap timeout, then a fresh command
    send(8'hA2); send(8'h00); send(8'h00); send(8'h00);
    tick(TO - 1);
    chk("to_before", {62'd0, busy, err_count == 8'd0}, 64'd3);
    tick(1);
    exp_err = exp_err + 8'd1;
    chk("to_err", {56'd0, err_count}, {56'd0, exp_err});
    chk("to_idle", {63'd0, busy}, 64'd0);
    exp_tx.push_back(8'h66);
    send(8'h25);
    wait_idle("to_next_idle");

    // bad opcodes and out-of-range indices
    send(8'h5F); exp_err = exp_err + 8'd1;
    chk("err_5F", {56'd0, err_count}, {56'd0, exp_err});
    send(8'h28); send(8'h14); send(8'hA4); exp_err = exp_err + 8'd3;
    chk("err_multi", {56'd0, err_count}, {56'd0, exp_err});
    send(8'h38); send(8'h10); exp_err = exp_err + 8'd1;
    chk("err_38_reparse", {55'd0, out_clk, err_count}, {55'd0, 1'b1, exp_err});
    send(8'h11);

    // overrun while a read is stalled
    exp_mem.push_back('{we: 1'b0, addr: 24'h000040, wdata: 16'h0000});
    send(8'hA1); send(8'h40); send(8'h00); send(8'h00);
    mem_expect("ovr");
    send(8'h10);
    chk("ovr_first", {56'd0, err_count}, {56'd0, exp_err});
    send(8'h10); exp_err = exp_err + 8'd1;
    chk("ovr_err", {56'd0, err_count}, {56'd0, exp_err});
    tick(2);
    chk("ovr_req_held", {63'd0, mem_req}, 64'd1);
    mem_ack_pulse(16'h5555);
    chk("ovr_abort", {63'd0, busy}, 64'd0);
    tick(3);
    chk("ovr_dropped", {62'd0, busy, out_clk}, 64'd0);

    // reset in the middle of a burst read
    exp_mem.push_back('{we: 1'b0, addr: 24'h000080, wdata: 16'h0000});
    exp_mem.push_back('{we: 1'b0, addr: 24'h000081, wdata: 16'h0000});
    send(8'hA3); send(8'h80); send(8'h00); send(8'h00); send(8'h03);
    mem_expect("rst_w0");
    exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
    mem_ack_pulse(16'h0201);
    mem_expect("rst_w1");
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mid_tx", {63'd0, tx_valid}, 64'd0);
    tick(2);
    sys_rst_n = 1'b1;
    exp_err = 8'd0;
    tick(5);
    chk("rst_after", {61'd0, mem_req, tx_valid, busy}, 64'd0);
    chk("rst_after_err", {56'd0, err_count}, 64'd0);
    chk("rst_after_out", out_pins, 64'd0);

    // error counter saturation
    for (int i = 0; i < 254; i++) send(8'hFF);
    chk("sat_FE", {56'd0, err_count}, 64'h0FE);
    send(8'hFF);
    chk("sat_FF", {56'd0, err_count}, 64'h0FF);
    send(8'hFF); send(8'hFF);
    chk("sat_hold", {56'd0, err_count}, 64'h0FF);

    tick(3);
    chk("tx_drain", 64'(exp_tx.size()), 64'd0);
    chk("mem_drain", 64'(exp_mem.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
